// File: rtl/muldiv_ctrl_pkg.sv
// Shared funct codes and sequencer state encodings for the
// HI/LO multiply/divide unit.
package muldiv_ctrl_pkg;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_MUL  = 2'd1;
  localparam logic [1:0] MD_DIV  = 2'd2;
  localparam logic [1:0] MD_FIX  = 2'd3;

  function automatic logic is_hilo_op(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MTHI) ||
           (f == F_MFLO) || (f == F_MTLO) ||
           (f == F_MULT) || (f == F_MULTU) ||
           (f == F_DIV)  || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or the
// restoring divider; purely combinational.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] low_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] dif;

  always_comb begin
    sum = {1'b0, acc} + (low[0] ? {1'b0, opb} : '0);
    shl = {acc, low[WIDTH-1]};
    dif = shl - {1'b0, opb};
    acc_nxt = sum[WIDTH:1];
    low_nxt = {sum[0], low[WIDTH-1:1]};
    if (div) begin
      // A negative trial difference means restore.
      if (dif[WIDTH]) begin
        acc_nxt = shl[WIDTH-1:0];
        low_nxt = {low[WIDTH-2:0], 1'b0};
      end else begin
        acc_nxt = dif[WIDTH-1:0];
        low_nxt = {low[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, iteration counter,
// sign correction, HI/LO registers and pipeline stall.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] opb;
  logic             op_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] low_nxt;

  logic             st_mul;
  logic             st_div;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   q_f;
  logic [WIDTH-1:0]   r_f;

  assign busy  = (state != MD_IDLE);
  assign stall = valid & is_hilo_op(funct) & busy;

  always_comb begin
    mf_data = '0;
    if (valid && funct == F_MFHI) mf_data = hi;
    if (valid && funct == F_MFLO) mf_data = lo;
  end

  always_comb begin
    st_mul = (funct == F_MULT) || (funct == F_MULTU);
    st_div = (funct == F_DIV) || (funct == F_DIVU);
    sgn    = (funct == F_MULT) || (funct == F_DIV);
    a_neg  = sgn & rs_val[WIDTH-1];
    b_neg  = sgn & rt_val[WIDTH-1];
    a_mag  = a_neg ? -rs_val : rs_val;
    b_mag  = b_neg ? -rt_val : rt_val;
  end

  // A zero divisor keeps the all-ones quotient unsigned.
  always_comb begin
    prod   = {acc, low};
    prod_f = neg_q ? -prod : prod;
    q_f    = (neg_q & ~dz) ? -low : low;
    r_f    = neg_r ? -acc : acc;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div     (op_div),
    .acc     (acc),
    .low     (low),
    .opb     (opb),
    .acc_nxt (acc_nxt),
    .low_nxt (low_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      acc    <= '0;
      low    <= '0;
      opb    <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      unique case (state)
        MD_IDLE: begin
          if (valid && !flush) begin
            if (st_mul || st_div) begin
              state  <= st_div ? MD_DIV : MD_MUL;
              cnt    <= '0;
              acc    <= '0;
              low    <= st_div ? a_mag : b_mag;
              opb    <= st_div ? b_mag : a_mag;
              op_div <= st_div;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              dz     <= st_div && (rt_val == '0);
            end
            if (funct == F_MTHI) hi <= rs_val;
            if (funct == F_MTLO) lo <= rs_val;
          end
        end
        MD_MUL, MD_DIV: begin
          if (flush) begin
            state <= MD_IDLE;
          end else begin
            acc <= acc_nxt;
            low <= low_nxt;
            if (cnt == CW'(WIDTH - 1)) begin
              state <= MD_FIX;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        MD_FIX: begin
          state <= MD_IDLE;
          if (!flush) begin
            if (op_div) begin
              hi <= r_f;
              lo <= q_f;
            end else begin
              {hi, lo} <= prod_f;
            end
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule
